uart_tx_sched: RTL and testbench

Transmit scheduler between the `io` block and the `uart` core. It queues bytes written by the CPU into a FIFO and arbitrates those writes against an optional RX-echo requester. It sequences the uart `tx_wr`/`tx_done` handshake so that exactly one byte is in flight at a time. This frees the CPU from polling `tx_done` before every byte.

---
 rtl/uart_sched_pkg.sv | 13 +
 rtl/uart_tx_sched_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_sched.sv | 113 +++++++++++
 tb/tb_uart_tx_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the uart transmit scheduler.
// FSM state encodings and the default FIFO depth.
package uart_sched_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sched_sync_fifo.sv
// Generic single-clock FIFO with registered count/full/empty; pushes while full
// and pops while empty are ignored. Pointers wrap modulo 2^DEPTH_LOG2.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  push_ok;
  logic                  pop_ok;

  // Acceptance is judged on the pre-edge occupancy only.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok)
      count_next = count + (DEPTH_LOG2 + 1)'(1);
    else if (!push_ok && pop_ok)
      count_next = count - (DEPTH_LOG2 + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Queues CPU bytes for the uart and keeps exactly one byte in flight.
// Optional RX echo path enabled by defining UART_TX_ECHO_EN.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  clr_ovf,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_done
);

  tx_state_e  state;
  logic       push_req;
  logic [7:0] push_byte;
  logic       fifo_pop;
  logic [7:0] fifo_head;
  logic       ovf_set;

`ifdef UART_TX_ECHO_EN
  logic       hold_valid;
  logic [7:0] hold_data;
  logic       hold_drain;
  logic       echo_drop;

  // The hold register leaves on any cycle without a CPU write, whether the
  // FIFO accepts it or drops it as full.
  assign hold_drain = hold_valid && !wr;
  assign echo_drop  = rx_done && hold_valid && !hold_drain;
  assign push_req   = wr || hold_valid;
  assign push_byte  = wr ? wr_data : hold_data;
  assign ovf_set    = (push_req && full) || echo_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (rx_done && !echo_drop) begin
      hold_valid <= 1'b1;
      hold_data  <= rx_data;
    end else if (hold_drain) begin
      hold_valid <= 1'b0;
    end
  end
`else
  logic unused_rx;

  assign unused_rx = ^{rx_data, rx_done};
  assign push_req  = wr;
  assign push_byte = wr_data;
  assign ovf_set   = push_req && full;
`endif

  assign fifo_pop = (state == ST_IDLE) && !empty;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push_req),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (ovf_set)
      overflow <= 1'b1;
    else if (clr_ovf)
      overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      tx_wr   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_wr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            tx_data <= fifo_head;
            tx_wr   <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: if (tx_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a depth-16 instance with a stallable uart
// model and a depth-4 instance for pointer wrap-around.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  logic       a_wr, a_clr_ovf, a_rx_done, a_full, a_empty, a_overflow, a_tx_wr;
  logic [7:0] a_wr_data, a_rx_data, a_tx_data;
  logic [4:0] a_count;
  logic       a_tx_done = 1'b0;

  logic       b_wr, b_clr_ovf, b_rx_done, b_full, b_empty, b_overflow, b_tx_wr;
  logic [7:0] b_wr_data, b_rx_data, b_tx_data;
  logic [2:0] b_count;
  logic       b_tx_done = 1'b0;

  uart_tx_sched u_a (
    .clk(clk), .rst(rst), .wr(a_wr), .wr_data(a_wr_data), .full(a_full), .empty(a_empty),
    .count(a_count), .overflow(a_overflow), .clr_ovf(a_clr_ovf), .rx_data(a_rx_data),
    .rx_done(a_rx_done), .tx_data(a_tx_data), .tx_wr(a_tx_wr), .tx_done(a_tx_done)
  );

  uart_tx_sched #(.DEPTH_LOG2(2)) u_b (
    .clk(clk), .rst(rst), .wr(b_wr), .wr_data(b_wr_data), .full(b_full), .empty(b_empty),
    .count(b_count), .overflow(b_overflow), .clr_ovf(b_clr_ovf), .rx_data(b_rx_data),
    .rx_done(b_rx_done), .tx_data(b_tx_data), .tx_wr(b_tx_wr), .tx_done(b_tx_done)
  );

  // Uart model A: tx_done 20 cycles after tx_wr unless stalled; logs bytes,
  // spacing from tx_done to the next tx_wr, and back-to-back tx_wr pulses.
  bit         a_stall = 1'b0;
  bit         a_pend, a_prev;
  int         a_cnt, a_since, a_pulses = 0, a_dbl = 0, a_peak = 0;
  logic [7:0] a_log[$];
  int         a_gaps[$];

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      a_pend = 0; a_tx_done = 1'b0; a_prev = 0; a_since = 100;
    end else begin
      a_since++;
      if (a_count > a_peak) a_peak = a_count;
      if (a_tx_wr) begin
        a_pulses++; a_log.push_back(a_tx_data); a_gaps.push_back(a_since);
        if (a_prev) a_dbl++;
        a_pend = 1; a_cnt = 20;
      end else if (a_tx_done) begin
        a_tx_done = 1'b0;
      end else if (a_pend && !a_stall) begin
        if (a_cnt > 1) a_cnt--;
        else begin a_tx_done = 1'b1; a_pend = 0; a_since = 0; end
      end
      a_prev = a_tx_wr;
    end
  end

  // Uart model B: tx_done 3 cycles after tx_wr.
  bit         b_pend, b_prev;
  int         b_cnt, b_pulses = 0, b_dbl = 0;
  logic [7:0] b_log[$];

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      b_pend = 0; b_tx_done = 1'b0; b_prev = 0;
    end else begin
      if (b_tx_wr) begin
        b_pulses++; b_log.push_back(b_tx_data);
        if (b_prev) b_dbl++;
        b_pend = 1; b_cnt = 3;
      end else if (b_tx_done) begin
        b_tx_done = 1'b0;
      end else if (b_pend) begin
        if (b_cnt > 1) b_cnt--;
        else begin b_tx_done = 1'b1; b_pend = 0; end
      end
      b_prev = b_tx_wr;
    end
  end

  task automatic wait_idle_a(output bit ok);
    ok = 0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (a_empty && !a_pend && !a_tx_done && !a_tx_wr) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle_b(output bit ok);
    ok = 0;
    for (int g = 0; g < 2000; g++) begin
      @(negedge clk);
      if (b_empty && !b_pend && !b_tx_done && !b_tx_wr) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    a_wr = 0; a_wr_data = '0; a_clr_ovf = 0; a_rx_done = 0; a_rx_data = '0;
    b_wr = 0; b_wr_data = '0; b_clr_ovf = 0; b_rx_done = 0; b_rx_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (a_tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr: got %b want 0", a_tx_wr); end
    checks++; if (a_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", a_tx_data); end
    checks++; if (a_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_count); end
    checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty %b full %b want 1 0", a_empty, a_full); end
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", a_overflow); end
    checks++; if (b_count !== 3'd0 || b_empty !== 1'b1) begin errors++; $display("FAIL reset_b: count %0d empty %b want 0 1", b_count, b_empty); end
    rst = 1'b1;
  endtask

  task automatic test_single_byte;
    int base;
    bit ok;
    base = a_pulses;
    a_stall = 1;
    @(negedge clk); a_wr = 1; a_wr_data = 8'h41;
    @(negedge clk); a_wr = 0;
    checks++; if (a_count !== 5'd1 || a_empty !== 1'b0) begin errors++; $display("FAIL single_after_push: count %0d empty %b want 1 0", a_count, a_empty); end
    checks++; if (a_tx_wr !== 1'b0) begin errors++; $display("FAIL single_early_tx_wr: got %b want 0", a_tx_wr); end
    @(negedge clk);
    checks++; if (a_tx_wr !== 1'b1 || a_tx_data !== 8'h41) begin errors++; $display("FAIL single_strobe: tx_wr %b data %h want 1 41", a_tx_wr, a_tx_data); end
    checks++; if (a_count !== 5'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL single_popped: count %0d empty %b want 0 1", a_count, a_empty); end
    @(negedge clk);
    checks++; if (a_tx_wr !== 1'b0) begin errors++; $display("FAIL single_strobe_len: got %b want 0", a_tx_wr); end
    a_wr = 1; a_wr_data = 8'h42;
    @(negedge clk); a_wr = 0;
    repeat (10) @(negedge clk);
    checks++; if (a_count !== 5'd1 || a_pulses != base + 1) begin errors++; $display("FAIL single_wait_holds: count %0d pulses %0d want 1 %0d", a_count, a_pulses, base + 1); end
    checks++; if (a_tx_data !== 8'h41) begin errors++; $display("FAIL single_data_hold: got %h want 41", a_tx_data); end
    a_stall = 0;
    wait_idle_a(ok);
    checks++; if (!ok || a_pulses != base + 2) begin errors++; $display("FAIL single_release: idle %b pulses %0d want 1 %0d", ok, a_pulses, base + 2); end
    else begin
      checks++; if (a_log[base] !== 8'h41 || a_log[base+1] !== 8'h42) begin errors++; $display("FAIL single_order: got %h %h want 41 42", a_log[base], a_log[base+1]); end
    end
  endtask

  task automatic test_burst;
    int base, gbase, bad_data, bad_gap;
    bit ok;
    base = a_pulses; gbase = a_gaps.size(); a_peak = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); a_wr = 1; a_wr_data = 8'(i);
    end
    @(negedge clk); a_wr = 0;
    wait_idle_a(ok);
    checks++; if (!ok || a_pulses != base + 16) begin errors++; $display("FAIL burst_count: idle %b pulses %0d want 1 %0d", ok, a_pulses - base, 16); end
    else begin
      bad_data = 0; bad_gap = 0;
      for (int i = 0; i < 16; i++) if (a_log[base+i] !== 8'(i)) bad_data++;
      for (int i = 1; i < 16; i++) if (a_gaps[gbase+i] != 2) bad_gap++;
      checks++; if (bad_data != 0) begin errors++; $display("FAIL burst_order: %0d bytes out of order, want 0", bad_data); end
      checks++; if (bad_gap != 0) begin errors++; $display("FAIL burst_spacing: %0d gaps not 2 cycles after tx_done, want 0", bad_gap); end
    end
    checks++; if (a_peak != 15) begin errors++; $display("FAIL burst_peak: got %0d want 15", a_peak); end
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL burst_overflow: got %b want 0", a_overflow); end
  endtask

  task automatic test_overflow;
    a_stall = 1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 17) begin
        checks++; if (a_count !== 5'd16 || a_full !== 1'b1) begin errors++; $display("FAIL ovf_full: count %0d full %b want 16 1", a_count, a_full); end
        checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", a_overflow); end
      end
      a_wr = 1; a_wr_data = 8'h80 + 8'(i); a_clr_ovf = (i == 17);
    end
    @(negedge clk); a_wr = 0; a_clr_ovf = 0;
    checks++; if (a_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", a_overflow); end
    checks++; if (a_count !== 5'd16) begin errors++; $display("FAIL ovf_count_kept: got %0d want 16", a_count); end
    checks++; if (a_log[a_log.size()-1] !== 8'h80) begin errors++; $display("FAIL ovf_in_flight: got %h want 80", a_log[a_log.size()-1]); end
    a_clr_ovf = 1;
    @(negedge clk); a_clr_ovf = 0;
    checks++; if (a_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", a_overflow); end
  endtask

  task automatic test_reset_mid_wait;
    int base;
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); rst = 1'b1; a_stall = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); a_wr = 1; a_wr_data = 8'hC0 + 8'(i);
    end
    @(negedge clk); a_wr = 0;
    checks++; if (a_count !== 5'd5) begin errors++; $display("FAIL rstw_queued: got %0d want 5", a_count); end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (a_tx_wr !== 1'b0 || a_count !== 5'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL rstw_async: tx_wr %b count %0d empty %b want 0 0 1", a_tx_wr, a_count, a_empty); end
    @(negedge clk); rst = 1'b1; a_stall = 0;
    base = a_pulses;
    repeat (40) @(negedge clk);
    checks++; if (a_pulses != base || a_overflow !== 1'b0) begin errors++; $display("FAIL rstw_quiet: pulses %0d overflow %b want %0d 0", a_pulses, a_overflow, base); end
  endtask

  task automatic test_wrap_around;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int base, bad, guard, stuck;
    bit ok;
    base = b_pulses; stuck = 0;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      guard = 0;
      while (b_full && guard < 100) begin @(negedge clk); guard++; end
      if (guard >= 100) stuck++;
      d = 8'($urandom);
      b_wr = 1; b_wr_data = d; exp_q.push_back(d);
      @(negedge clk); b_wr = 0;
    end
    wait_idle_b(ok);
    checks++; if (!ok || stuck != 0 || b_pulses != base + 40) begin errors++; $display("FAIL wrap_count: idle %b stuck %0d pulses %0d want 1 0 40", ok, stuck, b_pulses - base); end
    else begin
      bad = 0;
      for (int i = 0; i < 40; i++) if (b_log[base+i] !== exp_q[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order: %0d bytes wrong, want 0", bad); end
    end
    checks++; if (b_overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b want 0", b_overflow); end
  endtask

`ifdef UART_TX_ECHO_EN
  task automatic test_echo;
    int base;
    bit ok;
    base = a_pulses;
    @(negedge clk); a_wr = 1; a_wr_data = 8'hA5; a_rx_done = 1; a_rx_data = 8'h5A;
    @(negedge clk); a_wr = 1; a_wr_data = 8'hC3; a_rx_done = 1; a_rx_data = 8'h77;
    @(negedge clk); a_wr = 0; a_rx_done = 0;
    checks++; if (a_overflow !== 1'b1) begin errors++; $display("FAIL echo_busy_drop: overflow %b want 1", a_overflow); end
    wait_idle_a(ok);
    checks++; if (!ok || a_pulses != base + 3) begin errors++; $display("FAIL echo_count: idle %b pulses %0d want 1 3", ok, a_pulses - base); end
    else begin
      checks++; if (a_log[base] !== 8'hA5 || a_log[base+1] !== 8'hC3 || a_log[base+2] !== 8'h5A) begin
        errors++; $display("FAIL echo_order: got %h %h %h want A5 C3 5A", a_log[base], a_log[base+1], a_log[base+2]);
      end
    end
  endtask
`endif

  task automatic test_strobe_width;
    checks++; if (a_dbl != 0 || b_dbl != 0) begin errors++; $display("FAIL tx_wr_width: double pulses a %0d b %0d want 0 0", a_dbl, b_dbl); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_burst;
    test_overflow;
    test_reset_mid_wait;
    test_wrap_around;
`ifdef UART_TX_ECHO_EN
    test_echo;
`endif
    test_strobe_width;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
